// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial system bus: FSM encoding, mode values,
// default slave-ID width and the beat-count helper used by master and slave ports.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEFAULT_SLAVE_ADDR_WIDTH = 4;

  // Number of LANES-wide beats needed to carry a field of the given width.
  function automatic int beat_count(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/serial_master_port_if.sv
// Device-side handshake plus serial bus signals of the master port.
// The master modport is the port's own view; the slave modport is the
// view of whatever drives the device requests and answers on the bus.
interface serial_master_port_if import serial_bus_pkg::*; #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int SLAVE_ADDR_WIDTH = DEFAULT_SLAVE_ADDR_WIDTH,
  parameter int LANES            = 1
);

  logic                        dvalid;
  logic                        dready;
  logic                        dmode;
  logic [ADDR_WIDTH-1:0]       daddr;
  logic [DATA_WIDTH-1:0]       dwdata;
  logic [DATA_WIDTH-1:0]       drdata;
  logic                        drvalid;
  logic                        derr;
  logic [SLAVE_ADDR_WIDTH-1:0] mslave;
  logic                        mbusy;
  logic                        mmode;
  logic [LANES-1:0]            mwdata;
  logic                        mvalid;
  logic [LANES-1:0]            mrdata;
  logic                        svalid;

  modport master (
    input  dvalid, dmode, daddr, dwdata, mrdata, svalid,
    output dready, drdata, drvalid, derr, mslave, mbusy, mmode, mwdata, mvalid
  );

  modport slave (
    output dvalid, dmode, daddr, dwdata, mrdata, svalid,
    input  dready, drdata, drvalid, derr, mslave, mbusy, mmode, mwdata, mvalid
  );

endinterface

// File: rtl/lane_shifter.sv
// Lane-wide serialiser/deserialiser shared by the master and slave ports.
// The shift register sends its contents LSB-first, LANES bits per beat;
// the collector writes each incoming beat into the word slot it names.
module lane_shifter import serial_bus_pkg::*; #(
  parameter int SHIFT_WIDTH   = 20,
  parameter int COLLECT_WIDTH = 8,
  parameter int LANES         = 1,
  parameter int SLOT_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [SHIFT_WIDTH-1:0]   load_data,
  input  logic                     shift,
  output logic [LANES-1:0]         beat_out,
  input  logic                     clear,
  input  logic                     capture,
  input  logic [SLOT_WIDTH-1:0]    slot,
  input  logic [LANES-1:0]         beat_in,
  output logic [COLLECT_WIDTH-1:0] collect_next
);

  logic [SHIFT_WIDTH-1:0]   sreg;
  logic [COLLECT_WIDTH-1:0] creg;

  assign beat_out = sreg[LANES-1:0];

  // Outgoing shift register: parallel load, then drop one beat per shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_data;
    end else if (shift) begin
      sreg <= sreg >> LANES;
    end
  end

  // Word as it would look with the current beat placed in its slot.
  always_comb begin
    collect_next = creg;
    collect_next[int'(slot)*LANES +: LANES] = beat_in;
  end

  // Incoming collector: cleared at the start of a read, updated per valid beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      creg <= '0;
    end else if (capture) begin
      creg <= collect_next;
    end
  end

endmodule

// File: rtl/serial_master_port.sv
// Master-side bridge from a parallel device request to the serial system bus.
// Presents the slave ID in parallel, serialises local address and write data
// over LANES bits per beat, and assembles read data with a read timeout.
module serial_master_port import serial_bus_pkg::*; #(
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int SLAVE_ADDR_WIDTH = DEFAULT_SLAVE_ADDR_WIDTH,
  parameter int LANES            = 1,
  parameter int TIMEOUT          = 255
) (
  input logic                  clk,
  input logic                  rst,
  serial_master_port_if.master bus
);

  localparam int LOCAL_WIDTH = ADDR_WIDTH - SLAVE_ADDR_WIDTH;
  localparam int AB          = beat_count(LOCAL_WIDTH, LANES);
  localparam int DB          = beat_count(DATA_WIDTH, LANES);
  localparam int SHIFT_WIDTH = LOCAL_WIDTH + DATA_WIDTH;
  localparam int MAX_BEATS   = (AB > DB) ? AB : DB;
  localparam int CNT_WIDTH   = $clog2(MAX_BEATS + 1);
  localparam int TCNT_WIDTH  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_WIDTH-1:0]  AB_LAST = CNT_WIDTH'(AB - 1);
  localparam logic [CNT_WIDTH-1:0]  DB_LAST = CNT_WIDTH'(DB - 1);
  localparam logic [TCNT_WIDTH-1:0] TO_LAST = TCNT_WIDTH'(TIMEOUT - 1);

  if ((LOCAL_WIDTH % LANES) != 0 || (DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide both the local address width and DATA_WIDTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t                      state, state_d;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [TCNT_WIDTH-1:0]       tcnt;
  logic                        accept;
  logic                        rd_done;
  logic                        rd_timeout;
  logic [DATA_WIDTH-1:0]       collect_next;

  logic                        mvalid_q, mvalid_d;
  logic                        drvalid_q, drvalid_d;
  logic                        derr_q, derr_d;
  logic [DATA_WIDTH-1:0]       drdata_q, drdata_d;
  logic [SLAVE_ADDR_WIDTH-1:0] mslave_q, mslave_d;
  logic                        mmode_q, mmode_d;

  assign accept     = (state == ST_IDLE) && bus.dvalid;
  assign rd_done    = (state == ST_RDATA) && bus.svalid && (cnt == DB_LAST);
  assign rd_timeout = (state == ST_RDATA) && !rd_done && (tcnt == TO_LAST);

  assign bus.dready  = (state == ST_IDLE);
  assign bus.mbusy   = (state != ST_IDLE);
  assign bus.mvalid  = mvalid_q;
  assign bus.drvalid = drvalid_q;
  assign bus.derr    = derr_q;
  assign bus.drdata  = drdata_q;
  assign bus.mslave  = mslave_q;
  assign bus.mmode   = mmode_q;

  // Address and write data share one shift register so data follows address seamlessly.
  lane_shifter #(
    .SHIFT_WIDTH  (SHIFT_WIDTH),
    .COLLECT_WIDTH(DATA_WIDTH),
    .LANES        (LANES),
    .SLOT_WIDTH   (CNT_WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .load_data   ({(bus.dmode == MODE_WRITE) ? bus.dwdata : {DATA_WIDTH{1'b0}},
                   bus.daddr[LOCAL_WIDTH-1:0]}),
    .shift       ((state == ST_ADDR) || (state == ST_WDATA)),
    .beat_out    (bus.mwdata),
    .clear       ((state_d == ST_RDATA) && (state != ST_RDATA)),
    .capture     ((state == ST_RDATA) && bus.svalid),
    .slot        (cnt),
    .beat_in     (bus.mrdata),
    .collect_next(collect_next)
  );

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode; a completing read beat beats the timeout in the same cycle.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (bus.dvalid) state_d = ST_ADDR;
      ST_ADDR:  if (cnt == AB_LAST) state_d = (mmode_q == MODE_WRITE) ? ST_WDATA : ST_RDATA;
      ST_WDATA: if (cnt == DB_LAST) state_d = ST_DONE;
      ST_RDATA: if (rd_done || rd_timeout) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Beat and timeout counters restart on every state entry.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state)) begin
      cnt  <= '0;
      tcnt <= '0;
    end else begin
      if ((state == ST_ADDR) || (state == ST_WDATA) || ((state == ST_RDATA) && bus.svalid)) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
      if (state == ST_RDATA) begin
        tcnt <= tcnt + TCNT_WIDTH'(1);
      end
    end
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    mvalid_d  = (state_d == ST_ADDR) || (state_d == ST_WDATA);
    drvalid_d = (state_d == ST_DONE);
    derr_d    = (state_d == ST_DONE) && rd_timeout;
    drdata_d  = drdata_q;
    mslave_d  = mslave_q;
    mmode_d   = mmode_q;
    if (rd_done) begin
      drdata_d = collect_next;
    end else if (rd_timeout) begin
      drdata_d = '0;
    end
    if (accept) begin
      mslave_d = bus.daddr[ADDR_WIDTH-1:LOCAL_WIDTH];
      mmode_d  = bus.dmode;
    end
  end

  // Output registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mvalid_q  <= 1'b0;
      drvalid_q <= 1'b0;
      derr_q    <= 1'b0;
      drdata_q  <= '0;
      mslave_q  <= '0;
      mmode_q   <= 1'b0;
    end else begin
      mvalid_q  <= mvalid_d;
      drvalid_q <= drvalid_d;
      derr_q    <= derr_d;
      drdata_q  <= drdata_d;
      mslave_q  <= mslave_d;
      mmode_q   <= mmode_d;
    end
  end

endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: a one-lane port with default timeout and a
// four-lane port with a short timeout, each checked against a beat/response scoreboard.
module tb_serial_master_port;
  import serial_bus_pkg::*;

  localparam int AB0 = 12;
  localparam int DB0 = 8;
  localparam int AB1 = 3;
  localparam int DB1 = 2;
  localparam int TO1 = 10;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   beatQ0[$];
  int   beatQ1[$];
  int   respQ0[$];
  int   respQ1[$];
  int   lastRd0 = 0;
  int   lastRd1 = 0;

  serial_master_port_if #(.LANES(1)) bus0 ();
  serial_master_port_if #(.LANES(4)) bus1 ();

  serial_master_port #(.LANES(1), .TIMEOUT(255)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
  serial_master_port #(.LANES(4), .TIMEOUT(TO1)) u1 (.clk(clk), .rst(rst1), .bus(bus1));

  // free-running clock and cycle counter used for latency checks
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // hard stop in case something wedges the stimulus
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // expected serial beats (LSB-first) and write completions for one request
  task automatic pushExpect(input int unit, input logic mode, input logic [15:0] addr, input logic [7:0] wdata);
    if (unit == 0) begin
      for (int k = 0; k < AB0; k++) beatQ0.push_back((int'(addr) >> k) & 1);
      if (mode) begin
        for (int k = 0; k < DB0; k++) beatQ0.push_back((int'(wdata) >> k) & 1);
        respQ0.push_back(lastRd0);
      end
    end else begin
      for (int k = 0; k < AB1; k++) beatQ1.push_back((int'(addr) >> (4 * k)) & 15);
      if (mode) begin
        for (int k = 0; k < DB1; k++) beatQ1.push_back((int'(wdata) >> (4 * k)) & 15);
        respQ1.push_back(lastRd1);
      end
    end
  endtask

  // one request: wait for dready, drive for one edge, return the cycle-1 counter value
  task automatic applyStimulus(input int unit, input logic mode, input logic [15:0] addr,
                               input logic [7:0] wdata, output int acc);
    bit ready = 1'b0;
    for (int i = 0; i < 200 && !ready; i++) begin
      @(negedge clk);
      ready = (unit == 0) ? bus0.dready : bus1.dready;
    end
    checkOutput("dready before request", 32'(ready), 32'd1);
    if (unit == 0) begin
      bus0.dvalid = 1'b1; bus0.dmode = mode; bus0.daddr = addr; bus0.dwdata = wdata;
    end else begin
      bus1.dvalid = 1'b1; bus1.dmode = mode; bus1.daddr = addr; bus1.dwdata = wdata;
    end
    pushExpect(unit, mode, addr, wdata);
    @(posedge clk); #1;
    acc = cyc;
    bus0.dvalid = 1'b0;
    bus1.dvalid = 1'b0;
  endtask

  task automatic waitDone(input int unit, input int acc, input int expCycle, input string tag);
    bit seen = 1'b0;
    int rel = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (((unit == 0) ? bus0.drvalid : bus1.drvalid) === 1'b1) begin
        seen = 1'b1;
        rel  = cyc - acc + 1;
      end
    end
    checkOutput({tag, " drvalid seen"}, 32'(seen), 32'd1);
    checkOutput({tag, " drvalid cycle"}, rel, expCycle);
  endtask

  // four-lane read: optional svalid noise during ADDR, optional gap between data beats
  task automatic readU1(input logic [15:0] addr, input logic [3:0] b0, input logic [3:0] b1,
                        input int gap, input bit noise);
    int acc;
    applyStimulus(1, MODE_READ, addr, 8'h00, acc);
    respQ1.push_back(int'({b1, b0}));
    lastRd1 = int'({b1, b0});
    if (noise) begin
      bus1.svalid = 1'b1; bus1.mrdata = 4'h9;
    end
    repeat (AB1) begin @(posedge clk); #1; end
    bus1.svalid = 1'b1; bus1.mrdata = b0;
    @(posedge clk); #1;
    if (gap > 0) begin
      bus1.svalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus1.svalid = 1'b1; bus1.mrdata = b1;
    @(posedge clk); #1;
    bus1.svalid = 1'b0; bus1.mrdata = 4'h0;
    waitDone(1, acc, AB1 + 3 + gap, "u1 read");
    repeat (3) @(negedge clk);
    checkOutput("u1 drdata hold", 32'(bus1.drdata), 32'({b1, b0}));
  endtask

  // scoreboard for the one-lane port
  always @(negedge clk) begin
    if (!rst0) begin
      if (bus0.mvalid === 1'b1) begin
        checkOutput("u0 beat expected", 32'(beatQ0.size() > 0), 32'd1);
        if (beatQ0.size() > 0) checkOutput("u0 beat", 32'(bus0.mwdata), beatQ0.pop_front());
      end
      if (bus0.drvalid === 1'b1) begin
        checkOutput("u0 resp expected", 32'(respQ0.size() > 0), 32'd1);
        if (respQ0.size() > 0) checkOutput("u0 resp", 32'({bus0.derr, bus0.drdata}), respQ0.pop_front());
      end
    end
  end

  // scoreboard for the four-lane port
  always @(negedge clk) begin
    if (!rst1) begin
      if (bus1.mvalid === 1'b1) begin
        checkOutput("u1 beat expected", 32'(beatQ1.size() > 0), 32'd1);
        if (beatQ1.size() > 0) checkOutput("u1 beat", 32'(bus1.mwdata), beatQ1.pop_front());
      end
      if (bus1.drvalid === 1'b1) begin
        checkOutput("u1 resp expected", 32'(respQ1.size() > 0), 32'd1);
        if (respQ1.size() > 0) checkOutput("u1 resp", 32'({bus1.derr, bus1.drdata}), respQ1.pop_front());
      end
    end
  end

  // main sequence
  initial begin
    int  acc;
    bit  ready;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.dvalid = 1'b0; bus0.dmode = 1'b0; bus0.daddr = '0; bus0.dwdata = '0;
    bus0.mrdata = '0;   bus0.svalid = 1'b0;
    bus1.dvalid = 1'b0; bus1.dmode = 1'b0; bus1.daddr = '0; bus1.dwdata = '0;
    bus1.mrdata = '0;   bus1.svalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;

    @(negedge clk);
    checkOutput("reset dready", 32'(bus0.dready), 32'd1);
    checkOutput("reset mbusy", 32'(bus0.mbusy), 32'd0);
    checkOutput("reset mvalid", 32'(bus0.mvalid), 32'd0);
    checkOutput("reset drvalid", 32'(bus0.drvalid), 32'd0);
    checkOutput("reset drdata/derr", 32'({bus0.derr, bus0.drdata}), 32'd0);
    checkOutput("reset mslave", 32'(bus1.mslave), 32'd0);

    $display("[TB] one-lane write 0x3A5C <- 0xC3");
    applyStimulus(0, MODE_WRITE, 16'h3A5C, 8'hC3, acc);
    checkOutput("u0 mslave", 32'(bus0.mslave), 32'd3);
    checkOutput("u0 mmode", 32'(bus0.mmode), 32'd1);
    checkOutput("u0 busy dready", 32'({bus0.mbusy, bus0.dready}), 32'b10);
    waitDone(0, acc, AB0 + DB0 + 1, "u0 write");
    @(negedge clk);
    checkOutput("u0 dready after done", 32'({bus0.mbusy, bus0.dready}), 32'b01);

    $display("[TB] reset in the middle of a write");
    applyStimulus(0, MODE_WRITE, 16'h5123, 8'h5A, acc);
    repeat (4) begin @(posedge clk); #1; end
    rst0 = 1'b1;
    @(posedge clk); #1;
    beatQ0.delete();
    respQ0.delete();
    rst0 = 1'b0;
    checkOutput("abort mvalid", 32'(bus0.mvalid), 32'd0);
    checkOutput("abort mbusy", 32'(bus0.mbusy), 32'd0);
    checkOutput("abort dready", 32'(bus0.dready), 32'd1);
    checkOutput("abort mslave/mwdata", 32'({bus0.mslave, bus0.mwdata}), 32'd0);
    applyStimulus(0, MODE_WRITE, 16'h7E01, 8'h81, acc);
    checkOutput("after abort mslave", 32'(bus0.mslave), 32'd7);
    waitDone(0, acc, AB0 + DB0 + 1, "u0 after abort");

    $display("[TB] dvalid held through a write with changing address");
    ready = 1'b0;
    for (int i = 0; i < 200 && !ready; i++) begin
      @(negedge clk);
      ready = bus0.dready;
    end
    bus0.dvalid = 1'b1; bus0.dmode = MODE_WRITE; bus0.daddr = 16'h4C21; bus0.dwdata = 8'h5E;
    pushExpect(0, MODE_WRITE, 16'h4C21, 8'h5E);
    @(posedge clk); #1;
    acc = cyc;
    ready = 1'b0;
    for (int i = 0; i < 100 && !ready; i++) begin
      bus0.daddr  = 16'($urandom);
      bus0.dwdata = 8'($urandom);
      @(negedge clk);
      if (bus0.dready === 1'b1) ready = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("b2b dready returns", 32'(ready), 32'd1);
    checkOutput("b2b dready cycle", cyc - acc + 1, AB0 + DB0 + 2);
    bus0.daddr = 16'hB7F0; bus0.dwdata = 8'h0F;
    pushExpect(0, MODE_WRITE, 16'hB7F0, 8'h0F);
    @(posedge clk); #1;
    acc = cyc;
    bus0.dvalid = 1'b0;
    checkOutput("b2b second mslave", 32'(bus0.mslave), 32'hB);
    waitDone(0, acc, AB0 + DB0 + 1, "u0 b2b second");

    $display("[TB] four-lane reads");
    readU1(16'h1A5C, 4'h7, 4'hE, 1, 1'b0);
    readU1(16'h82D4, 4'h3, 4'hC, 0, 1'b1);

    $display("[TB] four-lane write");
    applyStimulus(1, MODE_WRITE, 16'hF0E1, 8'h96, acc);
    checkOutput("u1 mslave", 32'(bus1.mslave), 32'hF);
    waitDone(1, acc, AB1 + DB1 + 1, "u1 write");

    $display("[TB] four-lane read timeout");
    applyStimulus(1, MODE_READ, 16'h6123, 8'h00, acc);
    respQ1.push_back(32'h100);
    lastRd1 = 0;
    waitDone(1, acc, AB1 + 1 + TO1, "u1 timeout");

    repeat (3) @(negedge clk);
    checkOutput("u0 leftover beats", beatQ0.size(), 32'd0);
    checkOutput("u1 leftover beats", beatQ1.size(), 32'd0);
    checkOutput("u0 leftover resp", respQ0.size(), 32'd0);
    checkOutput("u1 leftover resp", respQ1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_master_port.md
# serial_master_port

Parametrised master-side bridge between a parallel master device and the serial system bus. Accepts one read or write request per handshake and presents the slave ID in parallel for the arbiter/decoder. Serialises the slave-local address (and write data) LSB-first over `LANES` bits per beat, and collects read data beat-wise under `svalid`. Compared with the single-bit port, it adds lane-width generalisation, a read timeout with an error response, and an explicit completion pulse to the device.

## Interface
- `ADDR_WIDTH`, 16, full device address width.
- `DATA_WIDTH`, 8, data word width.
- `SLAVE_ADDR_WIDTH`, 4, upper address bits selecting the slave; never serialised.
- `LANES`, 1, bus bits per beat. Must divide `ADDR_WIDTH-SLAVE_ADDR_WIDTH` and `DATA_WIDTH`; otherwise elaboration error.
- `TIMEOUT`, 255, maximum cycles spent in the read-data phase; ≥1.

Ports:
- `clk  in  1` the single clock; everything is on its rising edge.
- `rst  in  1` synchronous, active-high reset.
- `dvalid  in  1` device request valid.
- `dready  out  1` port can accept a request.
- `dmode  in  1` 0 read, 1 write.
- `daddr  in  ADDR_WIDTH` request address.
- `dwdata  in  DATA_WIDTH` write data.
- `drdata  out  DATA_WIDTH` read data, valid with `drvalid`.
- `drvalid  out  1` one-cycle completion pulse (read and write).
- `derr  out  1` read timed out; qualified by `drvalid`.
- `mslave  out  SLAVE_ADDR_WIDTH` captured slave ID, held for the whole transfer.
- `mbusy  out  1` transfer in progress (accept+1 through the DONE cycle).
- `mmode  out  1` captured mode.
- `mwdata  out  LANES` address/write-data beat.
- `mvalid  out  1` `mwdata` valid.
- `mrdata  in  LANES` read-data beat.
- `svalid  in  1` `mrdata` valid.

## Operation
- Derived values:
  - AB = (ADDR_WIDTH-SLAVE_ADDR_WIDTH)/LANES address beats.
  - DB = DATA_WIDTH/LANES data beats.
  - Beat k carries bits `[k*LANES +: LANES]`.
- FSM states:
  - IDLE → ADDR on `dvalid && dready`. Captures `daddr`, `dwdata` and `dmode`.
  - ADDR: AB consecutive beats with `mvalid`=1. After the last beat, go to WDATA if mode is 1, otherwise RDATA.
  - WDATA: DB consecutive beats with `mvalid`=1, then DONE.
  - RDATA: `mvalid`=0. On each `svalid` cycle, store `mrdata` into beat slot k and increment k. After beat DB-1 is stored, go to DONE with `derr`=0. If the phase cycle count reaches `TIMEOUT` first, go to DONE with `derr`=1 and `drdata`=0.
  - DONE: `drvalid`=1 for exactly one cycle, then IDLE.
- `dready` = (state==IDLE). `dvalid` is ignored while not ready.
- `svalid` outside RDATA is ignored. In the final timeout cycle, a valid beat that completes the word wins (no error).
- Beat counter and timeout counter are separate. Both clear on every state entry.
- `drdata` holds its last value until the next DONE.
- Reset, including mid-transfer: return to IDLE and abort the transfer. All outputs are 0 except `dready`, which is 1 from the first cycle after reset deassertion.

## Timing
- All outputs are registered except `dready` and `mbusy`, which are decoded from state.
- Acceptance happens at edge 0.
  - Address beats are presented in cycles 1..AB.
  - Write: data beats in cycles AB+1..AB+DB; `drvalid` in cycle AB+DB+1; `dready` high again in cycle AB+DB+2.
  - Read: `drvalid` in the cycle after the edge that samples the last `svalid` beat.
- Minimum write occupancy is AB+DB+2 cycles. No back-to-back overlap.

## Structure
- Shared `serial_bus_pkg` contains:
  - the state encoding (IDLE, ADDR, WDATA, RDATA, DONE);
  - `MODE_READ`=0 and `MODE_WRITE`=1;
  - the default `SLAVE_ADDR_WIDTH`;
  - a beat-count helper function.
- Sub-module `lane_shifter`, reused by the slave port: a parallel-in/LANES-out shift register plus a LANES-in/parallel-out collector, with load/shift/capture enables.

## Test plan
- Write, defaults, `daddr`=0x3A5C, `dwdata`=0xC3, `dmode`=1 →
  - `mslave`=3;
  - `mwdata` = 0,0,1,1,1,0,1,0,0,1,0,1 then 1,1,0,0,0,0,1,1 in cycles 1–20;
  - `drvalid` in cycle 21 with `derr`=0.
- Read, LANES=4, `daddr`=0x1A5C, slave returns beats 0x7 and 0xE with a one-cycle `svalid` gap →
  - address beats 0xC, 0x5, 0xA;
  - `drdata`=0xE7, `derr`=0.
- Read, TIMEOUT=10, slave silent → `drvalid` 10 cycles after RDATA entry, `derr`=1, `drdata`=0x00.
- Reset asserted in cycle 5 of a write → next cycle has `mvalid`=0, `mbusy`=0, `dready`=1; the next request completes normally.
- `dvalid` held high throughout a write with changing `daddr` → only the first request is transferred. The second is accepted in the cycle `dready` rises.
- `svalid` pulses during ADDR → ignored; the read word is still assembled only from RDATA beats.
